tetris_sequencer: RTL and testbench
===================================

TETRIS_SEQUENCER -- requirements
Module: tetris_sequencer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge system clock.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  level; begins a game when sampled high in IDLE.
REQ-004 SHALL have port tick  input  1  single-cycle gravity pulse.
REQ-005 SHALL have port collide_down  input  1  high when the active piece moved one row down would overlap the settled map or leave the board.
REQ-006 SHALL have port color_map_r  input  [0:7][0:7]  settled map; row r is full when color_map_r[r]==8'hFF.
REQ-007 SHALL have port cur_y  output  4  active-piece row origin.
REQ-008 SHALL have port color  output  1  piece-visible / merge-enable strobe to the map.
REQ-009 SHALL have port load_next_block  output  1  one-cycle merge command to the map.
REQ-010 SHALL have port remove_line  output  8  one-hot row-removal command; bit r targets row r.
REQ-011 SHALL have port new_piece  output  1  one-cycle request to the piece generator.
REQ-012 SHALL have port score  output  8  count of removed rows.
REQ-013 SHALL have port game_over  output  1  level; terminal state flag.
REQ-014 SHALL have port state  output  3  encoding IDLE=0, SPAWN=1, FALL=2, LOCK=3, SCAN=4, REMOVE=5, GAME_OVER=6.

Function
REQ-015 SHALL drive all outputs from registers only, with no combinational input-to-output path.
REQ-016 SHALL in IDLE move to SPAWN when start=1 and clear score in the same edge; tick is ignored.
REQ-017 SHALL in SPAWN, a 1-cycle state: set cur_y<=0, assert new_piece for exactly that cycle, then move to FALL.
REQ-018 SHALL in FALL, on tick with collide_down=0 and cur_y<7, increment cur_y by 1 and remain in FALL.
REQ-019 SHALL in FALL, on tick with collide_down=1 or cur_y==7, move to LOCK with cur_y unchanged.
REQ-020 SHALL in FALL without tick hold cur_y and state; collide_down is sampled only when tick=1.
REQ-021 SHALL assert color=1 in SPAWN, FALL and LOCK, and color=0 in all other states.
REQ-022 SHALL in LOCK, a 1-cycle state: assert load_next_block, then go to GAME_OVER if cur_y==0, else to SCAN.
REQ-023 SHALL in SCAN, when any row is full, load remove_line with the one-hot of the highest-index full row and move to REMOVE; with no full row, move to SPAWN with remove_line=0.
REQ-024 SHALL in REMOVE, a 1-cycle state: hold the one-hot remove_line, increment score saturating at 255, clear remove_line and return to SCAN.
REQ-025 SHALL keep remove_line zero outside REMOVE and never assert load_next_block and remove_line in the same cycle.
REQ-026 SHALL rescan in SCAN only after the map has absorbed the previous removal, one cycle after REMOVE; multiple full rows are therefore removed one per SCAN/REMOVE pair.
REQ-027 SHALL in GAME_OVER hold game_over=1, color=0, cur_y and score frozen, and ignore start and tick until reset.
REQ-028 SHALL ignore tick in every state except FALL, and ignore start in every state except IDLE.

Reset
REQ-029 SHALL on reset immediately force state=IDLE, cur_y=0, color=0, load_next_block=0, remove_line=0, new_piece=0, score=0, game_over=0, regardless of the current state, including mid-REMOVE or mid-LOCK.

Verification
REQ-030 SHALL be verified with: start pulse from IDLE -> SPAWN for 1 cycle with new_piece=1, then FALL with cur_y=0 and color=1.
REQ-031 SHALL be verified with: 3 ticks with collide_down=0, then a tick with collide_down=1 -> cur_y=3, one cycle of LOCK with load_next_block=1, then SCAN.
REQ-032 SHALL be verified with: rows 7 and 5 =8'hFF after lock, map model shifting on remove_line -> remove_line=8'h80 then 8'h40 (row 5 shifted to 6), score=2, then SPAWN.
REQ-033 SHALL be verified with: lock at cur_y=0 -> load_next_block pulse, then GAME_OVER with game_over=1; later start and tick cause no change.
REQ-034 SHALL be verified with: score preset to 255 and one full row -> score stays 255.
REQ-035 SHALL be verified with: reset asserted during REMOVE -> remove_line=0 and state=IDLE without waiting for a clock edge.

Source files
------------

// File: rtl/tetris_sequencer.sv
// Game-flow sequencer for an 8x8 falling-block game: spawns pieces, applies gravity,
// locks pieces into the map, clears full rows one at a time and keeps score.
module tetris_sequencer (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            tick,
  input  logic            collide_down,
  input  logic [0:7][0:7] color_map_r,
  output logic [3:0]      cur_y,
  output logic            color,
  output logic            load_next_block,
  output logic [7:0]      remove_line,
  output logic            new_piece,
  output logic [7:0]      score,
  output logic            game_over,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPAWN     = 3'd1,
    ST_FALL      = 3'd2,
    ST_LOCK      = 3'd3,
    ST_SCAN      = 3'd4,
    ST_REMOVE    = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_t;

  state_t      state_r;
  logic [3:0]  cur_y_r;
  logic        color_r;
  logic        load_next_block_r;
  logic [7:0]  remove_line_r;
  logic        new_piece_r;
  logic [7:0]  score_r;
  logic        game_over_r;
  logic [7:0]  full_onehot_s;

  // One-hot of the highest-index full row; later rows override earlier ones.
  always_comb begin
    full_onehot_s = 8'h00;
    for (int r = 0; r < 8; r++) begin
      full_onehot_s = (color_map_r[r] == 8'hFF) ? (8'h01 << r) : full_onehot_s;
    end
  end

  // Sequencer FSM; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      cur_y_r           <= 4'd0;
      color_r           <= 1'b0;
      load_next_block_r <= 1'b0;
      remove_line_r     <= 8'h00;
      new_piece_r       <= 1'b0;
      score_r           <= 8'd0;
      game_over_r       <= 1'b0;
    end else begin
      new_piece_r       <= 1'b0;
      load_next_block_r <= 1'b0;
      remove_line_r     <= 8'h00;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_SPAWN;
            score_r     <= 8'd0;
            cur_y_r     <= 4'd0;
            new_piece_r <= 1'b1;
            color_r     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SPAWN: begin
          state_r <= ST_FALL;
        end
        ST_FALL: begin
          if (tick) begin
            if (collide_down || (cur_y_r == 4'd7)) begin
              state_r           <= ST_LOCK;
              load_next_block_r <= 1'b1;
            end else begin
              cur_y_r <= cur_y_r + 4'd1;
            end
          end else begin
            state_r <= ST_FALL;
          end
        end
        ST_LOCK: begin
          color_r <= 1'b0;
          if (cur_y_r == 4'd0) begin
            state_r     <= ST_GAME_OVER;
            game_over_r <= 1'b1;
          end else begin
            state_r <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // The map has already absorbed any removal issued from the preceding REMOVE.
          if (full_onehot_s != 8'h00) begin
            state_r       <= ST_REMOVE;
            remove_line_r <= full_onehot_s;
          end else begin
            state_r     <= ST_SPAWN;
            cur_y_r     <= 4'd0;
            new_piece_r <= 1'b1;
            color_r     <= 1'b1;
          end
        end
        ST_REMOVE: begin
          state_r <= ST_SCAN;
          if (score_r != 8'hFF) begin
            score_r <= score_r + 8'd1;
          end else begin
            score_r <= score_r;
          end
        end
        ST_GAME_OVER: begin
          state_r <= ST_GAME_OVER;
        end
        default: begin
          state_r     <= ST_IDLE;
          cur_y_r     <= 4'd0;
          color_r     <= 1'b0;
          score_r     <= 8'd0;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

  assign state           = state_r;
  assign cur_y           = cur_y_r;
  assign color           = color_r;
  assign load_next_block = load_next_block_r;
  assign remove_line     = remove_line_r;
  assign new_piece       = new_piece_r;
  assign score           = score_r;
  assign game_over       = game_over_r;

endmodule

// File: tb/tb_tetris_sequencer.sv
// Scoreboard bench for tetris_sequencer: stimulus queues expected output snapshots,
// a monitor compares each output change against the queue head.
module tb_tetris_sequencer;

  logic            clk;
  logic            reset;
  logic            start;
  logic            tick;
  logic            collide_down;
  logic [3:0]      cur_y;
  logic            color;
  logic            load_next_block;
  logic [7:0]      remove_line;
  logic            new_piece;
  logic [7:0]      score;
  logic            game_over;
  logic [2:0]      state;

  logic [0:7][0:7] map_q = '0;
  logic [0:7][0:7] map_wdata;
  logic            map_wr;
  logic            map_freeze;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] y;
    logic       col;
    logic       lnb;
    logic [7:0] rl;
    logic       np;
    logic [7:0] sc;
    logic       go;
  } snap_t;

  snap_t exp_q[$];
  snap_t prev;
  logic  mon_en;
  int    n_checks;
  int    n_fails;

  tetris_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .collide_down(collide_down),
    .color_map_r(map_q), .cur_y(cur_y), .color(color), .load_next_block(load_next_block),
    .remove_line(remove_line), .new_piece(new_piece), .score(score), .game_over(game_over),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map model: rows above a removed row drop by one, row 0 refills empty.
  function automatic logic [0:7][0:7] shift_map(input logic [0:7][0:7] m, input logic [7:0] rl);
    logic [0:7][0:7] res;
    int t;
    t = 0;
    for (int r = 0; r < 8; r++) if (rl[r]) t = r;
    for (int r = 0; r < 8; r++) begin
      if (r > t) res[r] = m[r];
      else if (r == 0) res[r] = 8'h00;
      else res[r] = m[r-1];
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (map_wr) map_q <= map_wdata;
    else if (!map_freeze && remove_line != 8'h00) map_q <= shift_map(map_q, remove_line);
  end

  function automatic snap_t mk(input int st, input int y, input int col, input int lnb,
                               input int rl, input int np, input int sc, input int go);
    snap_t s;
    s.st = 3'(st); s.y = 4'(y); s.col = 1'(col); s.lnb = 1'(lnb);
    s.rl = 8'(rl); s.np = 1'(np); s.sc = 8'(sc); s.go = 1'(go);
    return s;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function snap_t cur_snap();
    return mk(int'(state), int'(cur_y), int'(color), int'(load_next_block),
              int'(remove_line), int'(new_piece), int'(score), int'(game_over));
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d y=%0d col=%0b lnb=%0b rl=%02h np=%0b sc=%0d go=%0b",
                     s.st, s.y, s.col, s.lnb, s.rl, s.np, s.sc, s.go);
  endfunction

  task automatic monitor();
    snap_t c;
    snap_t e;
    forever begin
      @(negedge clk);
      c = cur_snap();
      if (mon_en && c !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_change: got %s, want no change", fmt(c));
        end else begin
          e = exp_q.pop_front();
          if (c !== e) begin
            n_fails++;
            $display("FAIL seq_step: got %s, want %s", fmt(c), fmt(e));
          end
        end
      end
      prev = c;
    end
  endtask

  task automatic check_now(input string name, input snap_t e);
    snap_t c;
    c = cur_snap();
    n_checks++;
    if (c !== e) begin
      n_fails++;
      $display("FAIL %s: got %s, want %s", name, fmt(c), fmt(e));
    end
  endtask

  // Returns at negedge+1 once every queued expectation has been matched.
  task automatic wait_empty(input string name, input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (k == bound) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_timeout: got %0d pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_tick(input logic c);
    tick = 1'b1;
    collide_down = c;
    @(posedge clk); #2;
    tick = 1'b0;
    collide_down = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fails = 0; mon_en = 1'b0;
    reset = 1'b1; start = 1'b0; tick = 1'b0; collide_down = 1'b0;
    map_wr = 1'b0; map_freeze = 1'b0; map_wdata = '0;
    fork monitor(); join_none

    repeat (2) @(posedge clk); #2;
    check_now("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    @(negedge clk); #1;
    mon_en = 1'b1;

    // tick in IDLE is ignored
    tick = 1'b1;
    repeat (3) @(posedge clk); #2;
    tick = 1'b0;
    check_now("idle_ignores_tick", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // piece 1: spawn (tick during SPAWN ignored), fall to row 3, lock, clear rows 7 and 5
    exp_q.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0));
    start = 1'b1; tick = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    tick = 1'b0;
    wait_empty("spawn1", 20);
    for (int y = 1; y <= 3; y++) begin
      exp_q.push_back(mk(2, y, 1, 0, 0, 0, 0, 0));
      pulse_tick(1'b0);
      @(posedge clk); #2;
    end
    wait_empty("fall1", 20);
    exp_q.push_back(mk(3, 3, 1, 1, 8'h00, 0, 0, 0));
    exp_q.push_back(mk(4, 3, 0, 0, 8'h00, 0, 0, 0));
    exp_q.push_back(mk(5, 3, 0, 0, 8'h80, 0, 0, 0));
    exp_q.push_back(mk(4, 3, 0, 0, 8'h00, 0, 1, 0));
    exp_q.push_back(mk(5, 3, 0, 0, 8'h40, 0, 1, 0));
    exp_q.push_back(mk(4, 3, 0, 0, 8'h00, 0, 2, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 8'h00, 1, 2, 0));
    exp_q.push_back(mk(2, 0, 1, 0, 8'h00, 0, 2, 0));
    tick = 1'b1; collide_down = 1'b1;
    @(posedge clk); #2;
    tick = 1'b0; collide_down = 1'b0;
    map_wdata = '0;
    map_wdata[7] = 8'hFF;
    map_wdata[5] = 8'hFF;
    map_wr = 1'b1;
    @(posedge clk); #2;
    map_wr = 1'b0;
    wait_empty("clear1", 40);

    // piece 2: falls to the floor row 7 and locks there without a collision
    for (int y = 1; y <= 7; y++) exp_q.push_back(mk(2, y, 1, 0, 0, 0, 2, 0));
    exp_q.push_back(mk(3, 7, 1, 1, 0, 0, 2, 0));
    exp_q.push_back(mk(4, 7, 0, 0, 0, 0, 2, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 0, 1, 2, 0));
    exp_q.push_back(mk(2, 0, 1, 0, 0, 0, 2, 0));
    for (int i = 0; i < 8; i++) pulse_tick(1'b0);
    wait_empty("floor2", 40);

    // piece 3: locks at row 0 -> game over, then start/tick have no effect
    exp_q.push_back(mk(3, 0, 1, 1, 0, 0, 2, 0));
    exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 2, 1));
    pulse_tick(1'b1);
    wait_empty("gameover3", 20);
    start = 1'b1; tick = 1'b1;
    repeat (4) @(posedge clk); #2;
    start = 1'b0; tick = 1'b0;
    check_now("game_over_hold", mk(6, 0, 0, 0, 0, 0, 2, 1));

    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check_now("reset_from_game_over", mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #2;
    reset = 1'b0;

    // score saturation: row 7 stays full, so every scan finds a row to remove
    map_wdata = '0;
    map_wdata[7] = 8'hFF;
    map_wr = 1'b1; map_freeze = 1'b1;
    @(posedge clk); #2;
    map_wr = 1'b0;
    @(negedge clk); #1;
    mon_en = 1'b1;
    exp_q.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(2, 0, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 1, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 1, 1, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 258; k++) begin
      exp_q.push_back(mk(5, 1, 0, 0, 8'h80, 0, sat(k), 0));
      exp_q.push_back(mk(4, 1, 0, 0, 8'h00, 0, sat(k + 1), 0));
    end
    exp_q.push_back(mk(5, 1, 0, 0, 8'h80, 0, 255, 0));
    pulse_start();
    @(posedge clk); #2;
    pulse_tick(1'b0);
    pulse_tick(1'b1);
    wait_empty("saturate", 1000);

    // asynchronous reset while in REMOVE
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check_now("reset_mid_remove", mk(0, 0, 0, 0, 0, 0, 0, 0));
    map_freeze = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
